// File: rtl/apb_coef_pkg.sv
// rtl/apb_coef_pkg.sv - shared state, strobe and address helpers for apb_coef_loader
// COEF_READBACK_VERIFY_EN adds the readback states.
package apb_coef_pkg;

  localparam logic [3:0] STRB_ALL  = 4'b1111;
  localparam logic [3:0] STRB_NONE = 4'b0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_MEMWAIT,
    S_SETUP,
    S_ACCESS,
    S_GAP,
    S_DONE
`ifdef COEF_READBACK_VERIFY_EN
    , S_RB_SETUP
    , S_RB_ACCESS
`endif
  } state_t;

  // Wide arithmetic; callers truncate to their address width, which gives the wrap.
  function automatic logic [63:0] apb_addr(input logic [63:0] base,
                                           input logic [63:0] idx,
                                           input logic [63:0] stride);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/apb_master_port.sv
// rtl/apb_master_port.sv - APB SETUP/ACCESS phase engine; a request accepted back-to-back on ack.
module apb_master_port
  import apb_coef_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              p_sel,
  output logic              p_ce,
  output logic              p_we,
  output logic [3:0]        p_strb,
  output logic [ADDR_W-1:0] p_addr,
  output logic [DATA_W-1:0] p_wdata,
  input  logic              p_rdy,
  input  logic [DATA_W-1:0] p_rdata
);

  assign ack   = p_sel & p_ce & p_rdy;
  assign rdata = p_rdata;

  // p_sel/p_ce double as the phase state: setup = sel & !ce, access = sel & ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_sel   <= 1'b0;
      p_ce    <= 1'b0;
      p_we    <= 1'b0;
      p_strb  <= STRB_NONE;
      p_addr  <= '0;
      p_wdata <= '0;
    end else if (p_sel && !p_ce) begin
      p_ce <= 1'b1;
    end else if (req && (!p_sel || ack)) begin
      p_sel   <= 1'b1;
      p_ce    <= 1'b0;
      p_we    <= write;
      p_strb  <= write ? STRB_ALL : STRB_NONE;
      p_addr  <= addr;
      p_wdata <= write ? wdata : '0;
    end else if (ack) begin
      p_sel   <= 1'b0;
      p_ce    <= 1'b0;
      p_we    <= 1'b0;
      p_strb  <= STRB_NONE;
      p_addr  <= '0;
      p_wdata <= '0;
    end
  end

endmodule

// File: rtl/apb_coef_loader.sv
// rtl/apb_coef_loader.sv - streams coefficient memory words into consecutive APB registers
// COEF_READBACK_VERIFY_EN adds a readback compare after every write.
module apb_coef_loader
  import apb_coef_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 8,
  parameter int ADDR_STRIDE = 1,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [IDX_W:0]    word_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IDX_W-1:0]  err_index,
  output logic              mem_rd_en,
  output logic [IDX_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              p_sel,
  output logic              p_ce,
  output logic              p_we,
  output logic [3:0]        p_strb,
  output logic [ADDR_W-1:0] p_addr,
  output logic [DATA_W-1:0] p_wdata,
  input  logic              p_rdy,
  input  logic [DATA_W-1:0] p_rdata
);

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t            state;
  logic [IDX_W:0]    idx;
  logic [IDX_W:0]    count_q;
  logic [IDX_W:0]    idx_inc;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [3:0]        gap_cnt;
  logic              req;
  logic              req_write;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              xfer_end;
  logic              word_end;

  assign cur_addr  = ADDR_W'(apb_addr(64'(base_q), 64'(idx), 64'(ADDR_STRIDE)));
  assign idx_inc   = idx + 1'b1;
  assign req_write = (state == S_MEMWAIT);

`ifdef COEF_READBACK_VERIFY_EN
  // The readback request is queued during the write access so it starts on the ack edge.
  assign req      = (state == S_MEMWAIT) || (state == S_ACCESS);
  assign xfer_end = (state == S_RB_ACCESS) && ack;
`else
  assign req      = (state == S_MEMWAIT);
  assign xfer_end = (state == S_ACCESS) && ack;
`endif

  assign word_end = (GAP_CYCLES == 0) ? xfer_end : ((state == S_GAP) && (gap_cnt == 4'd0));

  apb_master_port #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_port (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .write  (req_write),
    .addr   (cur_addr),
    .wdata  (mem_rdata),
    .ack    (ack),
    .rdata  (rdata),
    .p_sel  (p_sel),
    .p_ce   (p_ce),
    .p_we   (p_we),
    .p_strb (p_strb),
    .p_addr (p_addr),
    .p_wdata(p_wdata),
    .p_rdy  (p_rdy),
    .p_rdata(p_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      count_q   <= '0;
      base_q    <= '0;
      gap_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            count_q <= word_count;
            idx     <= '0;
            busy    <= 1'b1;
            if (word_count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_FETCH;
              mem_rd_en <= 1'b1;
              mem_addr  <= '0;
            end
          end
        end
        S_FETCH:   state <= S_MEMWAIT;
        S_MEMWAIT: state <= S_SETUP;
        S_SETUP:   state <= S_ACCESS;
`ifdef COEF_READBACK_VERIFY_EN
        S_ACCESS:    if (ack) state <= S_RB_SETUP;
        S_RB_SETUP:  state <= S_RB_ACCESS;
        S_RB_ACCESS: if (ack) state <= S_GAP;
`else
        S_ACCESS:    if (ack) state <= S_GAP;
`endif
        S_GAP:     if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default:   state <= S_IDLE;
      endcase
      if (xfer_end) gap_cnt <= GAP_LOAD;
      // Word bookkeeping overrides the per-state transition at the end of each word.
      if (word_end) begin
        idx <= idx_inc;
        if (idx_inc == count_q) begin
          state <= S_DONE;
          done  <= 1'b1;
        end else begin
          state     <= S_FETCH;
          mem_rd_en <= 1'b1;
          mem_addr  <= idx_inc[IDX_W-1:0];
        end
      end
    end
  end

`ifdef COEF_READBACK_VERIFY_EN
  logic [DATA_W-1:0] wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err       <= 1'b0;
      err_index <= '0;
      wdata_q   <= '0;
    end else begin
      if (state == S_MEMWAIT) wdata_q <= mem_rdata;
      if (state == S_IDLE && start) begin
        err       <= 1'b0;
        err_index <= '0;
      end else if (state == S_RB_ACCESS && ack && rdata != wdata_q && !err) begin
        err       <= 1'b1;
        err_index <= idx[IDX_W-1:0];
      end
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^rdata;
  assign err          = 1'b0;
  assign err_index    = '0;
`endif

endmodule

// File: tb/tb_apb_coef_loader.sv
// tb/tb_apb_coef_loader.sv - randomized self-checking bench for apb_coef_loader
// Build with COEF_READBACK_VERIFY_EN to exercise the readback path.
module tb_apb_coef_loader;

`ifdef COEF_READBACK_VERIFY_EN
  localparam int WC = 6 + 2;
`else
  localparam int WC = 4 + 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [8:0]  word_count = '0;
  logic        busy, done, err, mem_rd_en;
  logic [7:0]  err_index, mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        p_sel, p_ce, p_we, p_rdy;
  logic [3:0]  p_strb;
  logic [31:0] p_addr, p_wdata, p_rdata;

  apb_coef_loader #(.GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .err(err), .err_index(err_index),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .p_sel(p_sel), .p_ce(p_ce), .p_we(p_we), .p_strb(p_strb), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_rdy(p_rdy), .p_rdata(p_rdata)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, stall_cnt = 0, psel_seen = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] last_wr_addr = '0;
  logic [31:0] mem  [0:255];
  logic [31:0] regs [0:255];
  logic        rnd_mode = 1'b0, rnd_bit = 1'b0, wait_en = 1'b0, corrupt_en = 1'b0;
  int          acc_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [70:0] prev_bus = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Coefficient store: synchronous read, data one cycle after the strobe.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // Responder: register file, optional 3 wait states on address 5, optional random ready.
  always @(posedge clk) begin
    rnd_bit <= ($urandom_range(0, 2) != 0);
    acc_cnt <= (p_sel && p_ce && !p_rdy) ? acc_cnt + 1 : 0;
    if (p_sel && p_ce && p_rdy && p_we) regs[p_addr[7:0]] <= p_wdata;
  end
  assign p_rdy   = rnd_mode ? rnd_bit
                 : (acc_cnt >= ((wait_en && p_we && p_addr == 32'd5) ? 3 : 0));
  assign p_rdata = regs[p_addr[7:0]] ^ ((corrupt_en && p_addr == 32'd9) ? 32'h1 : 32'h0);

  // Bus monitor: every completed write is scored against the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (p_ce) chk("ce_implies_sel", p_sel, 1);
      if (prev_stall) chk("hold_stable", {p_sel, p_ce, p_we, p_strb, p_addr, p_wdata}, prev_bus);
      if (p_sel) psel_seen++;
      if (p_sel && p_ce && !p_rdy) begin
        stall_cnt++;
        prev_stall = 1'b1;
        prev_bus   = {p_sel, p_ce, p_we, p_strb, p_addr, p_wdata};
      end else begin
        prev_stall = 1'b0;
      end
      if (p_sel && p_ce && p_rdy) begin
        if (p_we) begin
          wr_cnt++;
          if (exp_addr.size() == 0) begin
            chk("unexpected_write_queue", exp_addr.size(), 1);
          end else begin
            chk("wr_addr", p_addr, exp_addr.pop_front());
            chk("wr_data", p_wdata, exp_data.pop_front());
            chk("wr_strb", p_strb, 4'hF);
          end
          last_wr_addr = p_addr;
        end else begin
          rd_cnt++;
          chk("rd_addr", p_addr, last_wr_addr);
          chk("rd_strb", p_strb, 4'h0);
        end
      end
    end
  end

  task automatic run(input logic [31:0] base, input int n, input int lit, input bit poke_done);
    int t0;
    int guard;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 32'(i);
      exp_addr.push_back(a);
      exp_data.push_back(mem[i]);
    end
    stall_cnt = 0; psel_seen = 0; wr_cnt = 0; rd_cnt = 0;
    chk("busy_before", busy, 0);
    base_addr = base; word_count = 9'(n); start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0; base_addr = $urandom; word_count = 9'($urandom_range(1, 300));
    guard = 0;
    while (!done && guard < 5000) begin @(negedge clk); guard++; end
    chk("done_seen", done, 1);
    chk("latency_model", 32'(cyc - t0), 32'(1 + n * WC + stall_cnt));
    if (lit >= 0) chk("latency_literal", 32'(cyc - t0), 32'(lit));
    chk("busy_in_done", busy, 1);
    chk("writes_pending", exp_addr.size(), 0);
    chk("write_count", wr_cnt, n);
    if (poke_done) begin start = 1'b1; word_count = 9'd1; end
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 256; i++) begin mem[i] = 32'h100 + 32'(i); regs[i] = '0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ctrl", {busy, done, err, err_index, mem_rd_en, mem_addr, p_sel, p_ce, p_we, p_strb}, 0);
    chk("reset_bus", {p_addr, p_wdata}, 0);

    // Baseline 16-word load, then start poked in the done cycle.
    run(32'h0, 16, 1 + 16 * WC, 1'b1);
    chk("done_poke_ignored", busy, 0);
`ifndef COEF_READBACK_VERIFY_EN
    chk("no_reads", rd_cnt, 0);
`endif

    // Three wait states on word 5.
    wait_en = 1'b1;
    run(32'h0, 16, 1 + 16 * WC + 3, 1'b0);
    chk("wait_stalls", stall_cnt, 3);
    wait_en = 1'b0;

    // Empty block.
    run(32'h0, 0, 1, 1'b0);
    chk("no_psel_on_zero", psel_seen, 0);

    // Re-pulsed start ignored; reset at word 7; fresh load from index 0.
    for (int i = 0; i < 16; i++) begin exp_addr.push_back(32'(i)); exp_data.push_back(mem[i]); end
    wr_cnt = 0;
    base_addr = 32'h0; word_count = 9'd16; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    base_addr = 32'h80; word_count = 9'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (!(p_sel && !p_ce && p_addr == 32'd7) && guard < 2000) begin @(negedge clk); guard++; end
    chk("reached_word7", p_addr, 7);
    chk("writes_before_rst", wr_cnt, 7);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ctrl", {busy, done, err, err_index, mem_rd_en, mem_addr, p_sel, p_ce, p_we, p_strb}, 0);
    chk("rst_bus", {p_addr, p_wdata}, 0);
    rst = 1'b0;
    exp_addr.delete(); exp_data.delete();
    @(negedge clk);
    chk("idle_after_rst", {busy, p_sel}, 0);
    run(32'h40, 4, 1 + 4 * WC, 1'b0);

    // Address wrap.
    run(32'hFFFF_FFFE, 4, 1 + 4 * WC, 1'b0);
    chk("wrap_last_addr", last_wr_addr, 32'h1);

`ifdef COEF_READBACK_VERIFY_EN
    corrupt_en = 1'b1;
    run(32'h0, 16, 1 + 16 * WC, 1'b0);
    chk("rb_err", err, 1);
    chk("rb_err_index", err_index, 9);
    chk("rb_read_count", rd_cnt, 16);
    corrupt_en = 1'b0;
    run(32'h0, 4, -1, 1'b0);
    chk("rb_err_cleared", err, 0);
`endif

    // Random contents, bases, lengths and responder ready.
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rnd_mode = 1'b1;
    for (int r = 0; r < 6; r++) run($urandom, $urandom_range(1, 24), -1, 1'b0);
    rnd_mode = 1'b0;

    // Full memory: word_count = 2^IDX_W.
    run($urandom, 256, 1 + 256 * WC, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
